// File: rtl/cpc_ram_pkg.sv
// Shared constants, FSM encoding and the mode-to-page mapping
// for the 512K CPC RAM expansion CPLD.
package cpc_ram_pkg;

    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_P3   = 3'd1;
    localparam logic [2:0] MODE_ALL  = 3'd2;
    localparam logic [2:0] MODE_M3   = 3'd3;
    localparam logic [2:0] MODE_P4   = 3'd4;
    localparam logic [2:0] MODE_P5   = 3'd5;
    localparam logic [2:0] MODE_P6   = 3'd6;
    localparam logic [2:0] MODE_P7   = 3'd7;

    localparam logic [1:0] GA_SEL = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ARM    = 2'd1;
    localparam state_t S_COMMIT = 2'd2;
    localparam state_t S_WAIT   = 2'd3;

    // Returns {hit, page}; page is meaningful only when hit is set.
    function automatic logic [2:0] map(
        input logic [2:0] mode,
        input logic [1:0] region,
        input logic       m3_en
    );
        logic [2:0] r;
        r = 3'b000;
        unique case (1'b1)
            (mode == MODE_P3): if (region == 2'd3) r = 3'b111;
            (mode == MODE_ALL): r = {1'b1, region};
            (mode == MODE_M3): if (m3_en && region == 2'd3) r = 3'b111;
            (mode[2]): if (region == 2'd1) r = {1'b1, mode[1:0]};
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpc_ram_cpld_iowr_capture.sv
// Debounced capture of Z80 OUT cycles: data must be stable for two
// edges of the strobe before a single commit pulse is issued.
module cpc_ram_iowr_capture
    import cpc_ram_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_ni,
    input  logic       iow_i,
    input  logic [7:0] d_i,
    output logic       commit_o,
    output logic [7:0] data_o
);

    state_t     state_q, state_d;
    logic [7:0] sample_q, sample_d;

    // Mealy pulse on the ARM->COMMIT edge so the mapping lands on that edge.
    assign commit_o = (state_q == S_ARM) && iow_i && (d_i == sample_q);
    assign data_o   = sample_q;

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        unique case (state_q)
            S_IDLE: begin
                if (iow_i) begin
                    state_d  = S_ARM;
                    sample_d = d_i;
                end
            end
            S_ARM:    state_d = commit_o ? S_COMMIT : S_IDLE;
            S_COMMIT: state_d = S_WAIT;
            S_WAIT:   if (!iow_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            sample_q <= 8'h00;
        end else if (!clr_ni) begin
            state_q  <= S_IDLE;
            sample_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
        end
    end

endmodule

// File: rtl/cpc_ram_cpld.sv
// Top of the RAM expansion CPLD: bank/mode register fed by the OUT
// capture, plus combinational SRAM and RAMDIS decode.
module cpc_ram_cpld
    import cpc_ram_pkg::*;
#(
    parameter int NUM_BANK_BITS = 3,
    parameter int MODE3_EN      = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_B,
    input  logic                     BUSRESET_B,
    input  logic                     MREQ_B,
    input  logic                     IOREQ_B,
    input  logic                     RD_B,
    input  logic                     WR_B,
    input  logic                     RAMRD_B,
    input  logic                     A15,
    input  logic                     A14,
    input  logic [7:0]               D,
    output logic [NUM_BANK_BITS+1:0] HIADR,
    output logic                     RAMCS_B,
    output logic                     RAMOE_B,
    output logic                     RAMWE_B,
    output logic                     RAMDIS,
    output logic                     READY
);

    logic [NUM_BANK_BITS-1:0] bank_q, bank_d;
    logic [2:0]               mode_q, mode_d;
    logic                     iow, commit, hit, acc;
    logic [7:0]               cap;
    logic [2:0]               hp;
    logic [1:0]               page;
    logic                     unused_rd;

    assign unused_rd = RD_B;
    assign iow       = !IOREQ_B && !WR_B && !A15;

    cpc_ram_iowr_capture u_cap (
        .clk_i    (CLK),
        .rst_ni   (RESET_B),
        .clr_ni   (BUSRESET_B),
        .iow_i    (iow),
        .d_i      (D),
        .commit_o (commit),
        .data_o   (cap)
    );

    always_comb begin
        bank_d = bank_q;
        mode_d = mode_q;
        if (commit && cap[7:6] == GA_SEL) begin
            bank_d = cap[3 +: NUM_BANK_BITS];
            mode_d = cap[2:0];
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            bank_q <= '0;
            mode_q <= MODE_NONE;
        end else if (!BUSRESET_B) begin
            bank_q <= '0;
            mode_q <= MODE_NONE;
        end else begin
            bank_q <= bank_d;
            mode_q <= mode_d;
        end
    end

    assign hp   = map(mode_q, {A15, A14}, MODE3_EN != 0);
    assign hit  = hp[2];
    assign page = hit ? hp[1:0] : 2'b00;
    assign acc  = !MREQ_B && hit && (!RAMRD_B || !WR_B);

    assign HIADR   = {bank_q, page};
    assign RAMCS_B = !acc;
    assign RAMDIS  = acc;
    assign RAMOE_B = !(acc && !RAMRD_B && WR_B);
    assign RAMWE_B = !(acc && !WR_B);
    assign READY   = 1'b1;

endmodule
